// File: rtl/usb_tx_responder_if.sv
// Handshake bundle between the endpoint/control logic, the payload FIFO and
// the host-side transmit port of usb_tx_responder.
interface usb_tx_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_pid;
  logic [15:0] req_len;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        host_tx_valid;
  logic [3:0]  host_tx_pid;
  logic [15:0] host_tx_len;
  logic [7:0]  host_tx_data;
  logic        host_tx_data_valid;
  logic        host_tx_crc_byte;
  logic        host_tx_ready;
  logic        busy;
  logic        err_bad_req;

  modport slave (
    input  req_valid, req_pid, req_len, pl_data, pl_valid, host_tx_ready,
    output req_ready, pl_ready, host_tx_valid, host_tx_pid, host_tx_len,
           host_tx_data, host_tx_data_valid, host_tx_crc_byte, busy, err_bad_req
  );

  modport master (
    output req_valid, req_pid, req_len, pl_data, pl_valid, host_tx_ready,
    input  req_ready, pl_ready, host_tx_valid, host_tx_pid, host_tx_len,
           host_tx_data, host_tx_data_valid, host_tx_crc_byte, busy, err_bad_req
  );
endinterface

// File: rtl/usb_tx_responder.sv
// Device-side USB transmit packetizer: turns one ACK/NAK/STALL/DATA request
// into a header, optional payload, CRC16 trailer and an inter-packet gap.
module usb_tx_responder #(
  parameter int MAX_PKT = 64,
  parameter int IPG     = 2
) (
  input logic           clk,
  input logic           rst,
  usb_tx_responder_if.slave bus
);

  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [15:0] GAP_LAST = (IPG > 0) ? 16'(IPG - 1) : 16'd0;

  typedef enum logic [2:0] {IDLE, HDR, DATA, CRC_LO, CRC_HI, GAP} state_t;

  state_t      state;
  logic [15:0] rem;
  logic [15:0] gap_cnt;
  logic [15:0] crc;
  logic [3:0]  pid_q;
  logic [15:0] len_q;
  logic        is_data_q;

  logic        req_is_data;
  logic        req_pid_ok;
  logic        req_bad;
  logic        accept;
  logic        beat;

  // Reflected CRC16 (poly 0xA001), one byte consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    req_is_data = (bus.req_pid == PID_DATA0) || (bus.req_pid == PID_DATA1);
    req_pid_ok  = (bus.req_pid inside {PID_ACK, PID_NAK, PID_STALL, PID_DATA0, PID_DATA1});
    req_bad     = !req_pid_ok || (req_is_data && (bus.req_len > 16'(MAX_PKT)));
    accept      = bus.req_valid && bus.req_ready;
    beat        = bus.pl_valid && bus.host_tx_ready;
  end

  assign bus.req_ready          = (state == IDLE) && !rst;
  assign bus.err_bad_req        = accept && req_bad;
  assign bus.busy               = (state != IDLE);
  assign bus.host_tx_valid      = (state == HDR);
  assign bus.host_tx_pid        = pid_q;
  assign bus.host_tx_len        = len_q;
  assign bus.host_tx_crc_byte   = (state == CRC_LO) || (state == CRC_HI);
  assign bus.pl_ready           = (state == DATA) && bus.host_tx_ready;
  assign bus.host_tx_data_valid = (state == DATA) ? bus.pl_valid : bus.host_tx_crc_byte;

  // Payload passes straight through; the trailer is the inverted CRC, low byte first.
  always_comb begin
    case (state)
      DATA:    bus.host_tx_data = bus.pl_data;
      CRC_LO:  bus.host_tx_data = ~crc[7:0];
      CRC_HI:  bus.host_tx_data = ~crc[15:8];
      default: bus.host_tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= 16'd0;
      gap_cnt   <= 16'd0;
      crc       <= 16'hFFFF;
      pid_q     <= 4'h0;
      len_q     <= 16'd0;
      is_data_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= HDR;
            crc   <= 16'hFFFF;
            // Rejected requests degrade to a zero-length STALL.
            if (req_bad) begin
              pid_q     <= PID_STALL;
              len_q     <= 16'd0;
              rem       <= 16'd0;
              is_data_q <= 1'b0;
            end else begin
              pid_q     <= bus.req_pid;
              len_q     <= req_is_data ? bus.req_len : 16'd0;
              rem       <= req_is_data ? bus.req_len : 16'd0;
              is_data_q <= req_is_data;
            end
          end
        end
        HDR: begin
          if (bus.host_tx_ready) begin
            gap_cnt <= 16'd0;
            if (!is_data_q)      state <= GAP;
            else if (rem != 0)   state <= DATA;
            else                 state <= CRC_LO;
          end
        end
        DATA: begin
          if (beat) begin
            crc <= crc16_byte(crc, bus.pl_data);
            rem <= rem - 16'd1;
            if (rem == 16'd1) state <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (bus.host_tx_ready) state <= CRC_HI;
        end
        CRC_HI: begin
          if (bus.host_tx_ready) begin
            gap_cnt <= 16'd0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_tx_responder.md
Name: usb_tx_responder

Overview:
Device-side transmit packetizer for the USB device core. It turns one response request from the endpoint/control logic (ACK, NAK, STALL, or a DATA0/DATA1 packet) into a framed packet on the host_tx_* interface toward the host model/PHY.
- Data packets stream their payload from the endpoint FIFO and end with a CRC16 (USB polynomial).
- A programmable inter-packet gap follows every packet.

Parameters:
- MAX_PKT, 64: largest legal DATA payload in bytes; larger requests are rejected.
- IPG, 2: idle cycles forced after each packet before the next request is accepted (0 legal).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  response request valid
- req_ready  out  1  request accepted when req_valid&req_ready
- req_pid  in  4  requested PID: ACK=4'h2, NAK=4'hA, STALL=4'hE, DATA0=4'h3, DATA1=4'hB
- req_len  in  16  payload length in bytes (DATA only; ignored for handshakes)
- pl_data  in  8  payload byte from endpoint FIFO
- pl_valid  in  1  pl_data valid
- pl_ready  out  1  payload byte consumed when pl_valid&pl_ready
- host_tx_valid  out  1  header strobe; pid/len valid
- host_tx_pid  out  4  transmitted PID
- host_tx_len  out  16  payload length (0 for handshakes)
- host_tx_data  out  8  payload or CRC byte
- host_tx_data_valid  out  1  host_tx_data valid
- host_tx_crc_byte  out  1  current data byte is a CRC byte
- host_tx_ready  in  1  downstream accepts header/data this cycle
- busy  out  1  high in any state other than IDLE
- err_bad_req  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (async, rst=1): state=IDLE, gap/byte counters=0, CRC=16'hFFFF. All outputs are 0 except req_ready, which is 0 while rst=1 and 1 in IDLE afterwards.
- State machine: IDLE, HDR, DATA, CRC_LO, CRC_HI, GAP.
- IDLE: req_ready=1. On acceptance, register pid/len and go to HDR next cycle. One-cycle latency from acceptance to host_tx_valid.
- Request rejection: a request is bad if its pid is not one of the five listed, or if it is DATA with req_len>MAX_PKT.
  - A bad request is still accepted and err_bad_req pulses in the acceptance cycle.
  - The packet sent is STALL with len=0.
- HDR: host_tx_valid=1 with pid/len stable, held until host_tx_ready=1.
  - On handshake, handshake pids go to GAP.
  - DATA with len>0 goes to DATA, with CRC initialised to 16'hFFFF.
  - DATA with len=0 goes to CRC_LO.
- DATA: pl_ready=host_tx_ready; host_tx_data=pl_data; host_tx_data_valid=pl_valid.
  - A byte transfers when pl_valid&host_tx_ready. Each transfer updates the CRC and decrements the remaining count.
  - After the last byte, go to CRC_LO.
  - pl_valid low stalls the packet without error; there is no timeout.
- CRC: CRC16-USB, reflected polynomial 16'hA001, init 16'hFFFF, processed LSB-first per byte. Transmitted value = ~crc.
- CRC_LO / CRC_HI: host_tx_data = (~crc)[7:0], then (~crc)[15:8].
  - host_tx_data_valid=1 and host_tx_crc_byte=1 in both states.
  - Each state advances on host_tx_ready. CRC_HI goes to GAP.
  - Zero-length packet: both CRC bytes are 8'h00.
- GAP: count IPG cycles, then go to IDLE. IPG=0 returns to IDLE on the next cycle. req_ready stays 0 throughout GAP.
- pl_ready is 0 outside DATA. The payload FIFO is never read for handshake or rejected requests.
- host_tx_len/host_tx_pid hold their last values after HDR until the next HDR. host_tx_valid is high only in HDR.
- Reset mid-packet: the packet is truncated immediately with no CRC bytes, and the block returns to IDLE.

Test Plan:
- Reset then idle: after rst deassert -> req_ready=1, host_tx_valid=0, pl_ready=0, busy=0.
- STALL request (pid 4'hE), host_tx_ready=1:
  - host_tx_valid=1 one cycle after accept, pid=4'hE, len=0.
  - No data beats, pl_ready never high.
  - req_ready returns 1 exactly 1+IPG cycles after HDR.
- DATA1 with len=9, payload 0x31..0x39 ("123456789"):
  - Header pid=4'hB, len=9, then 9 data beats.
  - CRC bytes 8'hC8 then 8'hB4, with host_tx_crc_byte=1 on both.
- DATA0 with len=0 -> header len=0, CRC bytes 8'h00, 8'h00, no pl_ready.
- Back-pressure during the 9-byte case: toggle host_tx_ready and pl_valid pseudo-randomly -> identical byte sequence and CRC, no duplicated or dropped byte.
- Rejected requests:
  - DATA0 with len=65, MAX_PKT=64 -> err_bad_req pulse, STALL header, no payload read.
  - Reset asserted mid-DATA -> outputs 0 immediately, next request proceeds normally.
